// File: rtl/simd_normalizer_pkg.sv
// Shared types, constants and lane-geometry helpers for the SIMD normalizer.
package simd_normalizer_pkg;

    localparam int W     = 64;
    localparam int LANES = 4;

    typedef logic [W-1:0] word_t;
    typedef logic [5:0]   cnt_t;

    typedef enum logic [1:0] {
        MODE_64  = 2'd0,
        MODE_32  = 2'd1,
        MODE_16  = 2'd2,
        MODE_RSV = 2'd3
    } mode_t;

    typedef enum logic {
        OP_NLZ = 1'b0,
        OP_NLS = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Start round is log2(lane width)-1; the reserved mode behaves as MODE_64.
    function automatic logic [2:0] lane_rnds(input mode_t mode);
        case (mode)
            MODE_32: lane_rnds = 3'd4;
            MODE_16: lane_rnds = 3'd3;
            default: lane_rnds = 3'd5;
        endcase
    endfunction

    function automatic int lane_width(input mode_t mode);
        case (mode)
            MODE_32: lane_width = 32;
            MODE_16: lane_width = 16;
            default: lane_width = 64;
        endcase
    endfunction

    function automatic int lane_count(input mode_t mode);
        case (mode)
            MODE_32: lane_count = 2;
            MODE_16: lane_count = 4;
            default: lane_count = 1;
        endcase
    endfunction

    function automatic word_t lane_mask(input mode_t mode);
        case (mode)
            MODE_32: lane_mask = 64'h0000_0000_FFFF_FFFF;
            MODE_16: lane_mask = 64'h0000_0000_0000_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/simd_normalizer_rnd.sv
// One normalization round: per active lane, test the top 2^rnd (NLZ) or
// 2^rnd+1 (NLS) bits and shift the lane left by 2^rnd on a hit.
module simd_normalizer_rnd
    import simd_normalizer_pkg::*;
(
    input  word_t            word_i,
    input  mode_t            mode_i,
    input  op_t              op_i,
    input  logic [2:0]       rnd_i,
    output word_t            word_o,
    output logic [LANES-1:0] hit_o
);

    int    lw_s;
    int    s_s;
    word_t mask_s;
    word_t lane_s;
    word_t top_s;
    word_t tst_s;
    word_t ones_s;
    logic  hit_s;

    // Lanes are left-aligned into a full word so one test serves every width.
    always_comb begin
        lw_s   = lane_width(mode_i);
        s_s    = 1 << rnd_i;
        mask_s = lane_mask(mode_i);
        word_o = word_i;
        hit_o  = '0;
        lane_s = '0;
        top_s  = '0;
        tst_s  = '0;
        ones_s = (64'd1 << (s_s + 1)) - 64'd1;
        hit_s  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            lane_s = (word_i >> (l * lw_s)) & mask_s;
            top_s  = lane_s << (W - lw_s);
            if (op_i == OP_NLZ) begin
                tst_s = top_s >> (W - s_s);
                hit_s = (tst_s == 64'd0);
            end else begin
                tst_s = top_s >> (W - 1 - s_s);
                hit_s = (tst_s == 64'd0) || (tst_s == ones_s);
            end
            if ((l < lane_count(mode_i)) && hit_s) begin
                hit_o[l] = 1'b1;
                word_o   = (word_o & ~(mask_s << (l * lw_s)))
                         | (((lane_s << s_s) & mask_s) << (l * lw_s));
            end else begin
                hit_o[l] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/simd_normalizer.sv
// Iterative SIMD normalizer: per-lane NLZ/NLS count plus left shift, one
// shift-stage power resolved per cycle, single operation in flight.
module simd_normalizer
    import simd_normalizer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [63:0] in_w,
    input  logic [1:0]  in_mode,
    input  logic        in_op,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [63:0] out_w,
    output logic [23:0] out_cnt,
    output logic [3:0]  out_zero
);

    state_t           state_q;
    mode_t            mode_q;
    op_t              op_q;
    logic [2:0]       rnd_q;
    word_t            work_q;
    logic [23:0]      cnt_q;
    logic [3:0]       zero_q;
    logic             out_vld_q;

    mode_t            mode_d;
    logic [3:0]       zero_d;
    logic [23:0]      cnt_d;
    word_t            rnd_w_s;
    logic [LANES-1:0] hit_s;
    logic             accept_s;

    assign in_rdy   = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_rdy);
    assign accept_s = in_vld & in_rdy;

    simd_normalizer_rnd u_rnd (
        .word_i (work_q),
        .mode_i (mode_q),
        .op_i   (op_q),
        .rnd_i  (rnd_q),
        .word_o (rnd_w_s),
        .hit_o  (hit_s)
    );

    // Decode the incoming operand: fold the reserved mode and flag all-zero lanes.
    always_comb begin
        mode_d = (in_mode == 2'd3) ? MODE_64 : mode_t'(in_mode);
        zero_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if (l < lane_count(mode_d)) begin
                zero_d[l] = (((in_w >> (l * lane_width(mode_d))) & lane_mask(mode_d)) == 64'd0);
            end else begin
                zero_d[l] = 1'b0;
            end
        end
    end

    // Each hit sets count bit rnd of its lane.
    always_comb begin
        cnt_d = cnt_q;
        for (int l = 0; l < LANES; l++) begin
            if (hit_s[l]) begin
                cnt_d[l*6 +: 6] = cnt_q[l*6 +: 6] | cnt_t'(6'd1 << rnd_q);
            end else begin
                cnt_d[l*6 +: 6] = cnt_q[l*6 +: 6];
            end
        end
    end

    // Control FSM with working word, counts and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_64;
            op_q      <= OP_NLZ;
            rnd_q     <= 3'd0;
            work_q    <= '0;
            cnt_q     <= '0;
            zero_q    <= '0;
            out_vld_q <= 1'b0;
        end else if (accept_s) begin
            state_q   <= ST_BUSY;
            mode_q    <= mode_d;
            op_q      <= op_t'(in_op);
            rnd_q     <= lane_rnds(mode_d);
            work_q    <= in_w;
            cnt_q     <= '0;
            zero_q    <= zero_d;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_BUSY: begin
                    work_q <= rnd_w_s;
                    cnt_q  <= cnt_d;
                    if (rnd_q == 3'd0) begin
                        state_q   <= ST_DONE;
                        out_vld_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q - 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_rdy) begin
                        state_q   <= ST_IDLE;
                        out_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_vld  = out_vld_q;
    assign out_w    = work_q;
    assign out_cnt  = cnt_q;
    assign out_zero = zero_q;

endmodule

// File: tb/tb_simd_normalizer.sv
// Directed bench for simd_normalizer: vector table plus backpressure and reset-abort sequences.
module tb_simd_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [63:0] in_w;
    logic [1:0]  in_mode;
    logic        in_op;
    logic        out_vld;
    logic        out_rdy;
    logic [63:0] out_w;
    logic [23:0] out_cnt;
    logic [3:0]  out_zero;

    always #5 clk = ~clk;

    simd_normalizer dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_w     (in_w),
        .in_mode  (in_mode),
        .in_op    (in_op),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_w    (out_w),
        .out_cnt  (out_cnt),
        .out_zero (out_zero)
    );

    typedef struct {
        logic [1:0]  mode;
        logic        op;
        logic [63:0] w;
        logic [63:0] exp_w;
        logic [23:0] exp_cnt;
        logic [3:0]  exp_zero;
        int          lat;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] mode, input logic op, input logic [63:0] w);
        @(negedge clk);
        chk("in_rdy_at_accept", {63'd0, in_rdy}, 64'd1);
        in_vld  = 1'b1;
        in_mode = mode;
        in_op   = op;
        in_w    = w;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_vld(output int lat);
        lat = 1;
        while (!out_vld && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        chk("out_vld_after_pop", {63'd0, out_vld}, 64'd0);
    endtask

    task automatic check_result(input vec_t v, input int lat);
        chk("latency", 64'(lat), 64'(v.lat));
        chk("out_w", out_w, v.exp_w);
        chk("out_cnt", {40'd0, out_cnt}, {40'd0, v.exp_cnt});
        chk("out_zero", {60'd0, out_zero}, {60'd0, v.exp_zero});
    endtask

    initial begin
        int lat;
        int pulses;
        logic [63:0] junk;

        vecs[0] = '{2'd0, 1'b0, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, {18'd0, 6'd63}, 4'b0000, 7};
        vecs[1] = '{2'd2, 1'b0, 64'h0001_0080_1000_0000, 64'h8000_8000_8000_0000, {6'd15, 6'd8, 6'd3, 6'd15}, 4'b0001, 5};
        vecs[2] = '{2'd1, 1'b1, 64'hFFFF_FFF0_0000_00FF, 64'h8000_0000_7F80_0000, {12'd0, 6'd27, 6'd23}, 4'b0000, 6};
        vecs[3] = '{2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, {18'd0, 6'd63}, 4'b0000, 7};
        vecs[4] = '{2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, {18'd0, 6'd63}, 4'b0000, 7};
        vecs[5] = '{2'd0, 1'b0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, {18'd0, 6'd63}, 4'b0001, 7};
        vecs[6] = '{2'd0, 1'b1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, {18'd0, 6'd63}, 4'b0001, 7};
        vecs[7] = '{2'd1, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, {12'd0, 6'd31, 6'd0}, 4'b0010, 6};
        vecs[8] = '{2'd2, 1'b1, 64'h7FFF_8000_FFFF_0001, 64'h7FFF_8000_8000_4000, {6'd0, 6'd0, 6'd15, 6'd14}, 4'b0000, 5};
        vecs[9] = '{2'd0, 1'b0, 64'h0000_1234_0000_0000, 64'h91A0_0000_0000_0000, {18'd0, 6'd19}, 4'b0000, 7};

        rst     = 1'b1;
        in_vld  = 1'b0;
        in_w    = 64'd0;
        in_mode = 2'd0;
        in_op   = 1'b0;
        out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
        chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
        chk("rst_out_w", out_w, 64'd0);
        chk("rst_out_cnt", {40'd0, out_cnt}, 64'd0);
        chk("rst_out_zero", {60'd0, out_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            start_op(vecs[i].mode, vecs[i].op, vecs[i].w);
            wait_vld(lat);
            check_result(vecs[i], lat);
            pop();
        end

        // Backpressure, then pop and accept in the same cycle.
        start_op(vecs[1].mode, vecs[1].op, vecs[1].w);
        wait_vld(lat);
        check_result(vecs[1], lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            junk    = {$urandom, $urandom};
            in_vld  = 1'b1;
            in_w    = junk;
            in_mode = 2'd0;
            in_op   = 1'b1;
            #1;
            chk("bp_out_vld", {63'd0, out_vld}, 64'd1);
            chk("bp_in_rdy", {63'd0, in_rdy}, 64'd0);
            chk("bp_out_w", out_w, vecs[1].exp_w);
            chk("bp_out_cnt", {40'd0, out_cnt}, {40'd0, vecs[1].exp_cnt});
        end
        @(negedge clk);
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        in_w    = vecs[2].w;
        in_mode = vecs[2].mode;
        in_op   = vecs[2].op;
        #1;
        chk("popacc_in_rdy", {63'd0, in_rdy}, 64'd1);
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        chk("popacc_out_vld", {63'd0, out_vld}, 64'd0);
        wait_vld(lat);
        check_result(vecs[2], lat);
        pop();

        // Reset on the third BUSY cycle aborts the operation.
        start_op(vecs[0].mode, vecs[0].op, vecs[0].w);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_rdy", {63'd0, in_rdy}, 64'd1);
        chk("abort_out_vld", {63'd0, out_vld}, 64'd0);
        chk("abort_out_w", out_w, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_vld) pulses++;
        end
        chk("abort_no_result", 64'(pulses), 64'd0);
        chk("abort_idle_rdy", {63'd0, in_rdy}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
